// File: rtl/wf_reg_wr_arbiter.sv
// wf_reg_wr_arbiter: two-source FIFO'd round-robin write arbiter feeding a single-port register file.
// Optional out-of-range address drop enabled by defining WR_ADDR_CHECK_EN.
module wf_reg_wr_arbiter #(
  parameter int DEPTH       = 4,
  parameter int AW          = 6,
  parameter int DW          = 35,
  parameter int NUM_ENTRIES = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [AW-1:0]                 src0_addr,
  input  logic [DW-1:0]                 src0_data,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [AW-1:0]                 src1_addr,
  input  logic [DW-1:0]                 src1_data,
  input  logic                          wr_stall,
  output logic                          wr_en,
  output logic [AW-1:0]                 wr_addr,
  output logic [DW-1:0]                 wr_data,
  output logic [$clog2(2*DEPTH):0]      pending,
  output logic                          idle,
  output logic                          addr_err
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PDW = $clog2(2*DEPTH) + 1;
  logic [AW+DW-1:0] mem0_q [DEPTH];
  logic [AW+DW-1:0] mem1_q [DEPTH];
  logic [PW-1:0] wp0_q, rp0_q, wp1_q, rp1_q;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic rr_q, rr_d;
  logic wr_en_q, wr_en_d, addr_err_q;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic push0, push1, ne0, ne1, gnt0, gnt1, gnt, bad;
  logic [AW+DW-1:0] head;
  assign src0_ready = cnt0_q != CW'(DEPTH);
  assign src1_ready = cnt1_q != CW'(DEPTH);
  assign push0 = src0_valid & src0_ready;
  assign push1 = src1_valid & src1_ready;
  assign ne0 = cnt0_q != '0;
  assign ne1 = cnt1_q != '0;
  // rr_q=0 favours src0 when both heads are present
  assign gnt0 = ~wr_stall & ne0 & (~ne1 | ~rr_q);
  assign gnt1 = ~wr_stall & ne1 & (~ne0 | rr_q);
  assign gnt  = gnt0 | gnt1;
  assign head = gnt1 ? mem1_q[rp1_q] : mem0_q[rp0_q];
`ifdef WR_ADDR_CHECK_EN
  assign bad = gnt & (int'(head[AW+DW-1:DW]) >= NUM_ENTRIES);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    cnt0_d    = cnt0_q + CW'(push0) - CW'(gnt0);
    cnt1_d    = cnt1_q + CW'(push1) - CW'(gnt1);
    rr_d      = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
    wr_en_d   = gnt & ~bad;
    wr_addr_d = wr_en_d ? head[AW+DW-1:DW] : wr_addr_q;
    wr_data_d = wr_en_d ? head[DW-1:0] : wr_data_q;
  end
  always_ff @(posedge clk) begin
    if (push0) mem0_q[wp0_q] <= {src0_addr, src0_data};
    if (push1) mem1_q[wp1_q] <= {src1_addr, src1_data};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp0_q      <= '0;
      rp0_q      <= '0;
      wp1_q      <= '0;
      rp1_q      <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      rr_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wp0_q      <= wp0_q + PW'(push0);
      rp0_q      <= rp0_q + PW'(gnt0);
      wp1_q      <= wp1_q + PW'(push1);
      rp1_q      <= rp1_q + PW'(gnt1);
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      rr_q       <= rr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= bad;
    end
  end
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pending  = PDW'(cnt0_q) + PDW'(cnt1_q);
  assign idle     = (pending == '0) & ~wr_en_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_wf_reg_wr_arbiter.sv
// tb_wf_reg_wr_arbiter: vector-table and directed-sequence checks for wf_reg_wr_arbiter.
module tb_wf_reg_wr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic src0_valid = 1'b0, src1_valid = 1'b0, wr_stall = 1'b0;
  logic [5:0] src0_addr = '0, src1_addr = '0;
  logic [34:0] src0_data = '0, src1_data = '0;
  logic src0_ready, src1_ready, wr_en, idle, addr_err;
  logic [5:0] wr_addr;
  logic [34:0] wr_data;
  logic [3:0] pending;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wf_reg_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_addr(src1_addr), .src1_data(src1_data),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .idle(idle), .addr_err(addr_err)
  );
  typedef struct {
    logic rst, s, v0;
    logic [5:0] a0;
    logic [34:0] d0;
    logic v1;
    logic [5:0] a1;
    logic [34:0] d1;
    logic en;
    logic [5:0] ad;
    logic [34:0] da;
    logic [3:0] pe;
    logic r0, r1, id;
  } vec_t;
  vec_t tbl[26];
  function automatic vec_t mk(input logic r, s, v0, input logic [5:0] a0, input logic [34:0] d0,
                              input logic v1, input logic [5:0] a1, input logic [34:0] d1,
                              input logic en, input logic [5:0] ad, input logic [34:0] da,
                              input logic [3:0] pe, input logic r0, r1, id);
    vec_t v;
    v.rst = r; v.s = s; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.en = en; v.ad = ad; v.da = da; v.pe = pe; v.r0 = r0; v.r1 = r1; v.id = id;
    return v;
  endfunction
  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask
  task automatic drive(input logic v0, input logic [5:0] a0, input logic [34:0] d0,
                       input logic v1, input logic [5:0] a1, input logic [34:0] d1, input logic s);
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    wr_stall = s;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    // single write
    tbl[0]  = mk(0,0,1,5,35'h123456789, 0,0,0,  0,0,0,            1,1,1,0);
    tbl[1]  = mk(0,0,0,0,0,             0,0,0,  1,5,35'h123456789, 0,1,1,0);
    tbl[2]  = mk(0,0,0,0,0,             0,0,0,  0,5,35'h123456789, 0,1,1,1);
    tbl[3]  = mk(1,0,0,0,0,             0,0,0,  0,0,0,             0,1,1,1);
    // contention, interleaved without gaps
    tbl[4]  = mk(0,0,1,1,35'h11,  1,10,35'h1A,  0,0,0,       2,1,1,0);
    tbl[5]  = mk(0,0,1,2,35'h12,  1,11,35'h1B,  1,1,35'h11,  3,1,1,0);
    tbl[6]  = mk(0,0,1,3,35'h13,  1,12,35'h1C,  1,10,35'h1A, 4,1,1,0);
    tbl[7]  = mk(0,0,0,0,0,       0,0,0,        1,2,35'h12,  3,1,1,0);
    tbl[8]  = mk(0,0,0,0,0,       0,0,0,        1,11,35'h1B, 2,1,1,0);
    tbl[9]  = mk(0,0,0,0,0,       0,0,0,        1,3,35'h13,  1,1,1,0);
    tbl[10] = mk(0,0,0,0,0,       0,0,0,        1,12,35'h1C, 0,1,1,0);
    tbl[11] = mk(0,0,0,0,0,       0,0,0,        0,12,35'h1C, 0,1,1,1);
    // same address, RR at src0
    tbl[12] = mk(0,0,1,7,35'hA,   1,7,35'hB,    0,12,35'h1C, 2,1,1,0);
    tbl[13] = mk(0,0,0,0,0,       0,0,0,        1,7,35'hA,   1,1,1,0);
    tbl[14] = mk(0,0,0,0,0,       0,0,0,        1,7,35'hB,   0,1,1,0);
    tbl[15] = mk(0,0,0,0,0,       0,0,0,        0,7,35'hB,   0,1,1,1);
    // back-pressure: fill under stall, extra push refused, drain in order
    tbl[16] = mk(0,1,1,20,35'h100, 0,0,0,       0,7,35'hB,   1,1,1,0);
    tbl[17] = mk(0,1,1,21,35'h101, 0,0,0,       0,7,35'hB,   2,1,1,0);
    tbl[18] = mk(0,1,1,22,35'h102, 0,0,0,       0,7,35'hB,   3,1,1,0);
    tbl[19] = mk(0,1,1,23,35'h103, 0,0,0,       0,7,35'hB,   4,0,1,0);
    tbl[20] = mk(0,1,1,24,35'h1FF, 0,0,0,       0,7,35'hB,   4,0,1,0);
    tbl[21] = mk(0,0,1,24,35'h1FF, 0,0,0,       1,20,35'h100,3,1,1,0);
    tbl[22] = mk(0,0,0,0,0,        0,0,0,       1,21,35'h101,2,1,1,0);
    tbl[23] = mk(0,0,0,0,0,        0,0,0,       1,22,35'h102,1,1,1,0);
    tbl[24] = mk(0,0,0,0,0,        0,0,0,       1,23,35'h103,0,1,1,0);
    tbl[25] = mk(0,0,0,0,0,        0,0,0,       0,23,35'h103,0,1,1,1);
    #2;
    chk("rst_wr_en", -1, wr_en, 0);
    chk("rst_pending", -1, pending, 0);
    chk("rst_idle", -1, idle, 1);
    chk("rst_wr_addr", -1, wr_addr, 0);
    chk("rst_wr_data", -1, wr_data, 0);
    chk("rst_addr_err", -1, addr_err, 0);
    step();
    rst = 1'b0;
    chk("rdy0_after_rst", -1, src0_ready, 1);
    chk("rdy1_after_rst", -1, src1_ready, 1);
    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].s);
      step();
      rst = 1'b0;
      chk("wr_en", i, wr_en, tbl[i].en);
      chk("wr_addr", i, wr_addr, tbl[i].ad);
      chk("wr_data", i, wr_data, tbl[i].da);
      chk("pending", i, pending, tbl[i].pe);
      chk("src0_ready", i, src0_ready, tbl[i].r0);
      chk("src1_ready", i, src1_ready, tbl[i].r1);
      chk("idle", i, idle, tbl[i].id);
      chk("addr_err", i, addr_err, 0);
    end
    // async reset mid-burst: one write out, three still queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(30 + i), 35'(i), 0, 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("burst_wr_en", 0, wr_en, 1);
    chk("burst_pending", 0, pending, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 0, wr_en, 0);
    chk("async_rst_pending", 0, pending, 0);
    chk("async_rst_idle", 0, idle, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_write", i, wr_en, 0);
      chk("post_rst_pending", i, pending, 0);
    end
    // out-of-range address then a valid one
    do_reset();
    drive(1, 45, 35'h45, 0, 0, 0, 0);
    step();
    drive(1, 3, 35'h33, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef WR_ADDR_CHECK_EN
    chk("range_drop_wr_en", 0, wr_en, 0);
    chk("range_addr_err", 0, addr_err, 1);
    step();
    chk("range_next_wr_en", 1, wr_en, 1);
    chk("range_next_wr_addr", 1, wr_addr, 3);
    chk("range_err_cleared", 1, addr_err, 0);
`else
    chk("range_pass_wr_en", 0, wr_en, 1);
    chk("range_pass_wr_addr", 0, wr_addr, 45);
    chk("range_addr_err", 0, addr_err, 0);
    step();
    chk("range_next_wr_en", 1, wr_en, 1);
    chk("range_next_wr_addr", 1, wr_addr, 3);
    chk("range_next_wr_data", 1, wr_data, 35'h33);
`endif
    step();
    chk("range_final_idle", 2, idle, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
